fetch_stage: RTL

Instruction-fetch stage of the 5-stage pipelined MIPS core. It sits directly upstream of REG_IF_ID. It owns the PC, issues addresses to the synchronous IMEM (one-cycle read latency) and hands each returned instruction, with its PC and PC+4, to the IF/ID register. It supports stalls from the hazard unit, branch/jump redirects, exception vectoring and an external PC load. A one-entry skid buffer ensures that no instruction is lost or duplicated when a stall arrives while an IMEM read is in flight.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_skid.sv | 37 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Constants shared by the fetch stage, CONTROL and the pipeline registers.
// Also defines the per-cycle PC source selection used by fetch_stage.
package mips_pkg;

    localparam int ADDR_W  = 8;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [INST_W-1:0] NOP_INST   = 32'h0;
    localparam logic [ADDR_W-1:0] RESET_PC   = 8'h00;
    localparam logic [ADDR_W-1:0] EXC_VECTOR = 8'hF0;

    // Winning PC source for one cycle once reset is excluded, highest priority first.
    typedef enum logic [2:0] {
        PC_LOAD,
        PC_EXC,
        PC_REDIRECT,
        PC_HOLD,
        PC_ADVANCE
    } pc_sel_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction returned while fetch is stalled.
// Capture fills an empty entry, the entry holds while full, and clear releases it.
module fetch_skid #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              capture,
    input  logic [INST_W-1:0] new_inst,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc
);

    logic load;

    assign load = capture && !valid && !clear;

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload has no reset; it is only observed while valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            inst <= new_inst;
            pc   <= new_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues IMEM reads with one-cycle latency and
// presents each returned instruction with its PC; a one-entry skid covers stalls.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = mips_pkg::ADDR_W,
    parameter int                INST_W     = mips_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
) (
    input  logic              CLK,
    input  logic              SYS_reset,
    input  logic              IF_load,
    input  logic [ADDR_W-1:0] IF_pc_val,
    input  logic              IF_exception,
    input  logic              IF_redirect,
    input  logic [ADDR_W-1:0] IF_redirect_pc,
    input  logic              IF_stall,
    output logic [ADDR_W-1:0] IF_imem_addr,
    input  logic [INST_W-1:0] IF_imem_data,
    output logic              IF_valid,
    output logic [INST_W-1:0] IF_instruction,
    output logic [ADDR_W-1:0] IF_pc,
    output logic [ADDR_W-1:0] IF_pc_plus4
);

    logic [ADDR_W-1:0] pc;
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    pc_sel_e           pc_sel;

    logic              skid_valid;
    logic [INST_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_pc;

    always_comb begin
        if (IF_load) begin
            pc_sel = PC_LOAD;
        end else if (IF_exception) begin
            pc_sel = PC_EXC;
        end else if (IF_redirect) begin
            pc_sel = PC_REDIRECT;
        end else if (IF_stall) begin
            pc_sel = PC_HOLD;
        end else begin
            pc_sel = PC_ADVANCE;
        end
    end

    // NOTE: registers update with non-blocking assignments so every block samples pre-edge state.
    always_ff @(posedge CLK) begin
        if (SYS_reset) begin
            pc        <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            case (pc_sel)
                PC_LOAD: begin
                    pc        <= IF_pc_val;
                    req_valid <= 1'b0;
                end
                PC_EXC: begin
                    pc        <= EXC_VECTOR;
                    req_valid <= 1'b0;
                end
                PC_REDIRECT: begin
                    pc        <= IF_redirect_pc;
                    req_valid <= 1'b0;
                end
                PC_HOLD: begin
                    req_valid <= 1'b0;
                end
                default: begin
                    req_valid <= 1'b1;
                    req_pc    <= pc;
                    pc        <= pc + ADDR_W'(PC_STEP);
                end
            endcase
        end
    end

    // Any unstalled cycle consumes the skid; a stall captures the in-flight read once.
    fetch_skid #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_skid (
        .clk     (CLK),
        .clear   (SYS_reset || (pc_sel != PC_HOLD)),
        .capture (req_valid),
        .new_inst(IF_imem_data),
        .new_pc  (req_pc),
        .valid   (skid_valid),
        .inst    (skid_inst),
        .pc      (skid_pc)
    );

    // NOTE: every output is assigned on every path, so no latch is inferred.
    always_comb begin
        if (skid_valid) begin
            IF_valid       = 1'b1;
            IF_instruction = skid_inst;
            IF_pc          = skid_pc;
        end else begin
            IF_valid       = req_valid;
            IF_instruction = req_valid ? IF_imem_data : INST_W'(NOP_INST);
            IF_pc          = req_pc;
        end
    end

    assign IF_pc_plus4  = IF_pc + ADDR_W'(PC_STEP);
    assign IF_imem_addr = pc;

endmodule
